pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Fetch-stage program-counter sequencer; the consumer of the execute-stage PC-select code PCSrcE.
- Holds PCF and advances it sequentially, or redirects it to the branch/JAL/JALR target.
- Generates FlushD/FlushE for wrong-path instructions.
- If a redirect arrives while fetch cannot advance, the target is latched and applied on the next advancing cycle.

Parameters:
- XLEN, 32, address width.
- RESET_VECTOR, 32'h0000_0000, PCF value after reset.
- CNT_W, 16, width of the redirect event counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- StallF  input  1  hazard-unit fetch stall.
- imem_ready  input  1  instruction memory can accept a fetch this cycle.
- PCSrcE  input  2  00 sequential, 01 PCTargetE (taken branch/JAL), 10 JALR, 11 reserved.
- PCTargetE  input  XLEN  PCE+immediate target.
- ALUResultE  input  XLEN  JALR target rs1+imm.
- PCF  output  XLEN  current fetch address (registered).
- PCPlus4F  output  XLEN  PCF+4, combinational, wraps modulo 2^XLEN.
- FlushD  output  1  kill the instruction entering decode.
- FlushE  output  1  kill the instruction entering execute.
- redirect_pending  output  1  high while a latched target awaits application (state PEND).
- misaligned_err  output  1  registered one-cycle pulse: accepted redirect target had bit[1] set.
- redirect_count  output  CNT_W  accepted redirects; saturates at all-ones.

Behaviour:
- Reset (rst=1 at edge):
  - PCF=RESET_VECTOR, state=RUN, pending target=0.
  - misaligned_err=0, redirect_count=0.
  - rst overrides every other input, including a redirect in the same cycle.
- advance = ~StallF & imem_ready.
- redirect = (PCSrcE==01) | (PCSrcE==10). Code 11 is treated exactly as 00: no redirect, no flush, no count.
- Target selection:
  - 01: tgt = PCTargetE.
  - 10: tgt = {ALUResultE[XLEN-1:1],1'b0}.
  - The loaded value always has bits[1:0] forced to 00.
  - misaligned_err pulses the cycle after acceptance if the raw target bit[1] was 1, or if bit[0] was 1 for code 01.
- State RUN:
  - redirect & advance: PCF<=tgt at next edge; stay RUN.
  - redirect & ~advance: pend<=tgt; go PEND; PCF holds.
  - ~redirect & advance: PCF<=PCF+4.
  - ~redirect & ~advance: PCF holds.
- State PEND:
  - advance: PCF<=pend; go RUN. A new redirect in this same cycle wins: PCF<=new tgt.
  - ~advance: hold. A new redirect overwrites pend (newest wins).
- Flushes (combinational):
  - FlushE = redirect.
  - FlushD = redirect | (state==PEND). Decode stays killed until the correct target is fetched.
- An accepted redirect is any redirect cycle, whether applied directly or latched.
- redirect_count increments by 1 per accepted redirect and does not wrap.
- Latency: redirect seen in cycle N with advance → PCF=tgt in cycle N+1.
- PCF+4 wrap: all-ones-minus-3 → 0, no error.

Test Plan:
1. Reset then 4 advancing cycles, PCSrcE=00 → PCF 0,4,8,C,10; FlushD=FlushE=0; redirect_count=0.
2. At PCF=0x10, PCSrcE=01, PCTargetE=0x100, advance=1 → FlushD=FlushE=1 that cycle; next PCF=0x100; redirect_count=1; misaligned_err=0.
3. PCSrcE=10, ALUResultE=0x203, advance=1 → next PCF=0x200; misaligned_err pulses for one cycle (bit1=1); count increments.
4. StallF=1 and PCSrcE=01 with target 0x400 held for 3 cycles → redirect_pending=1 and FlushD=1 throughout; PCF unchanged. Release stall → PCF=0x400 next cycle; redirect_pending=0.
5. In PEND (target 0x400), new PCSrcE=01 target 0x500 with advance=0, then advance → PCF=0x500.
6. rst=1 in the same cycle as PCSrcE=01 → PCF=RESET_VECTOR, state RUN, count 0. Separately: PCSrcE=11 → sequential advance, no flush. Counter preloaded near saturation (CNT_W=2) with 5 redirects → stays 3.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-stage PC sequencer; advances PCF by 4 or redirects to branch/JAL/JALR target.
// Latency: a redirect seen with fetch advancing lands in PCF one cycle later; flushes are combinational.
// Backpressure: while fetch is stalled (StallF or !imem_ready) a redirect target is parked and applied on the next advancing cycle.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   StallF, imem_ready       - fetch may advance only when StallF=0 and imem_ready=1
//   PCSrcE                   - 00 seq, 01 PCTargetE, 10 JALR (ALUResultE), 11 treated as 00
//   PCTargetE, ALUResultE    - candidate redirect targets from execute
//   PCF, PCPlus4F            - current fetch address and its sequential successor (wraps)
//   FlushD, FlushE           - kill wrong-path instructions entering decode/execute
//   redirect_pending         - a parked target is waiting for fetch to advance
//   misaligned_err           - one-cycle pulse after accepting a target that is not word aligned
//   redirect_count           - saturating count of accepted redirects
module pc_redirect_unit #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             imem_ready,
  input  logic [1:0]       PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [XLEN-1:0]  ALUResultE,
  output logic [XLEN-1:0]  PCF,
  output logic [XLEN-1:0]  PCPlus4F,
  output logic             FlushD,
  output logic             FlushE,
  output logic             redirect_pending,
  output logic             misaligned_err,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pcf_q, pcf_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              advance;
  logic              redirect;
  logic              sel_jalr;
  logic [XLEN-1:0]   tgt_raw;
  logic [XLEN-1:0]   tgt;
  logic              tgt_misaligned;
  logic [XLEN-1:0]   pc_plus4;

  assign advance  = ~StallF & imem_ready;
  assign redirect = (PCSrcE == 2'b01) | (PCSrcE == 2'b10);
  assign sel_jalr = (PCSrcE == 2'b10);

  // JALR clears bit 0 of rs1+imm by definition, so only bit 1 can flag a
  // misaligned JALR target; a branch/JAL target is flagged on either low bit.
  assign tgt_raw        = sel_jalr ? ALUResultE : PCTargetE;
  assign tgt_misaligned = tgt_raw[1] | (tgt_raw[0] & ~sel_jalr);
  // Fetch is word addressed: the loaded PC always has its low two bits cleared.
  assign tgt            = {tgt_raw[XLEN-1:2], 2'b00};

  assign pc_plus4 = pcf_q + {{(XLEN-3){1'b0}}, 3'b100};

  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    pend_d  = pend_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;

    if (redirect) begin
      // Newest redirect always wins, both over a parked target and over
      // sequential advance.
      mis_d = tgt_misaligned;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (advance) begin
        pcf_d   = tgt;
        state_d = RUN;
      end else begin
        pend_d  = tgt;
        state_d = PEND;
      end
    end else if (advance) begin
      if (state_q == PEND) begin
        pcf_d   = pend_q;
        state_d = RUN;
      end else begin
        pcf_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pcf_q   <= RESET_VECTOR[XLEN-1:0];
      pend_q  <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCF              = pcf_q;
  assign PCPlus4F         = pc_plus4;
  assign FlushE           = redirect;
  // Decode keeps being killed until the parked target has actually been fetched.
  assign FlushD           = redirect | (state_q == PEND);
  assign redirect_pending = (state_q == PEND);
  assign misaligned_err   = mis_q;
  assign redirect_count   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic        imem_ready;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FlushD;
  logic        FlushE;
  logic        redirect_pending;
  logic        misaligned_err;
  logic [15:0] redirect_count;

  logic [31:0] s_PCF;
  logic [31:0] s_PCPlus4F;
  logic        s_FlushD;
  logic        s_FlushE;
  logic        s_pending;
  logic        s_mis;
  logic [1:0]  s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .StallF(StallF), .imem_ready(imem_ready),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .FlushD(FlushD), .FlushE(FlushE),
    .redirect_pending(redirect_pending), .misaligned_err(misaligned_err),
    .redirect_count(redirect_count)
  );

  // Narrow-counter copy for saturation.
  pc_redirect_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .StallF(StallF), .imem_ready(imem_ready),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .PCF(s_PCF), .PCPlus4F(s_PCPlus4F), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .redirect_pending(s_pending), .misaligned_err(s_mis),
    .redirect_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    StallF     = 1'b0;
    imem_ready = 1'b1;
    PCSrcE     = 2'b00;
    PCTargetE  = '0;
    ALUResultE = '0;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_cnt", redirect_count, 32'd0);
    chk("rst_pend", redirect_pending, 1'b0);
    chk("rst_mis", misaligned_err, 1'b0);
    chk("rst_flushd", FlushD, 1'b0);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      chk("seq_pcf", PCF, 32'(4 * i));
      chk("seq_flushe", FlushE, 1'b0);
      step();
    end
    chk("seq_pcf_end", PCF, 32'h10);
    chk("seq_cnt", redirect_count, 32'd0);

    // Taken branch with advance
    PCSrcE = 2'b01; PCTargetE = 32'h100;
    #1;
    chk("br_flushd", FlushD, 1'b1);
    chk("br_flushe", FlushE, 1'b1);
    step();
    PCSrcE = 2'b00;
    chk("br_pcf", PCF, 32'h100);
    chk("br_cnt", redirect_count, 32'd1);
    chk("br_mis", misaligned_err, 1'b0);

    // JALR with bit1 set: target 0x203 -> 0x200, error pulse
    PCSrcE = 2'b10; ALUResultE = 32'h203;
    step();
    PCSrcE = 2'b00;
    chk("jalr_pcf", PCF, 32'h200);
    chk("jalr_mis", misaligned_err, 1'b1);
    chk("jalr_cnt", redirect_count, 32'd2);
    step();
    chk("jalr_mis_clr", misaligned_err, 1'b0);
    chk("jalr_seq", PCF, 32'h204);

    // Redirect under stall for 3 cycles
    StallF = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_flushd", FlushD, 1'b1);
      step();
      chk("stall_pend", redirect_pending, 1'b1);
      chk("stall_pcf", PCF, 32'h204);
    end
    chk("stall_cnt", redirect_count, 32'd5);
    StallF = 1'b0; PCSrcE = 2'b00;
    #1;
    chk("rel_flushd", FlushD, 1'b1);
    chk("rel_flushe", FlushE, 1'b0);
    step();
    chk("rel_pcf", PCF, 32'h400);
    chk("rel_pend", redirect_pending, 1'b0);

    // PEND overwritten by newer target (imem not ready this time)
    StallF = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h400;
    step();
    StallF = 1'b0; imem_ready = 1'b0; PCTargetE = 32'h500;
    step();
    chk("ovr_pcf_hold", PCF, 32'h400);
    imem_ready = 1'b1; PCSrcE = 2'b00;
    step();
    chk("ovr_pcf", PCF, 32'h500);
    chk("ovr_cnt", redirect_count, 32'd7);

    // PEND + advance + new redirect: new target wins
    StallF = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h600;
    step();
    StallF = 1'b0; PCSrcE = 2'b10; ALUResultE = 32'h700;
    step();
    PCSrcE = 2'b00;
    chk("win_pcf", PCF, 32'h700);
    chk("win_pend", redirect_pending, 1'b0);

    // Branch target with bit0 set: flagged, loaded aligned
    PCSrcE = 2'b01; PCTargetE = 32'h101;
    step();
    PCSrcE = 2'b00;
    chk("b0_pcf", PCF, 32'h100);
    chk("b0_mis", misaligned_err, 1'b1);
    // JALR with only bit0 set: not flagged
    PCSrcE = 2'b10; ALUResultE = 32'h301;
    step();
    PCSrcE = 2'b00;
    chk("j0_pcf", PCF, 32'h300);
    chk("j0_mis", misaligned_err, 1'b0);

    // Reset overrides redirect, from PEND
    StallF = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h802;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; StallF = 1'b0; PCSrcE = 2'b00;
    chk("rr_pcf", PCF, 32'h0);
    chk("rr_cnt", redirect_count, 32'd0);
    chk("rr_pend", redirect_pending, 1'b0);
    chk("rr_mis", misaligned_err, 1'b0);
    step();
    chk("rr_seq", PCF, 32'h4);

    // Reserved code 11 behaves as sequential
    PCSrcE = 2'b11; PCTargetE = 32'h900; ALUResultE = 32'hA00;
    #1;
    chk("c11_flushd", FlushD, 1'b0);
    chk("c11_flushe", FlushE, 1'b0);
    step();
    PCSrcE = 2'b00;
    chk("c11_pcf", PCF, 32'h8);
    chk("c11_cnt", redirect_count, 32'd0);

    // PC+4 wrap at the top of the address space
    PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 2'b00;
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_plus4", PCPlus4F, 32'h0);
    step();
    chk("wrap_pcf0", PCF, 32'h0);
    chk("wrap_mis", misaligned_err, 1'b0);

    // Saturation on the 2-bit counter copy (it has seen 1 redirect since reset)
    chk("sat_start", s_count, 32'd1);
    PCSrcE = 2'b01; PCTargetE = 32'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_cnt", s_count, (i + 2 > 3) ? 32'd3 : 32'(i + 2));
    end
    PCSrcE = 2'b00;
    chk("sat_main_cnt", redirect_count, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
